// File: rtl/ysyx_25040129_pkg.sv
// Shared definitions for the writeback unit: FSM state encoding and the
// RV32 load funct3 codes understood by the load extender.
package ysyx_25040129_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wbu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_25040129_LDEXT.sv
// Load alignment check and sign/zero extension of the byte or halfword
// selected by the low address bits out of an aligned 32-bit response word.
module ysyx_25040129_LDEXT
    import ysyx_25040129_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lane[addr];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data     = rdata;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH: begin
                data     = {{16{half_sel[15]}}, half_sel};
                misalign = addr[0];
            end
            F3_LHU: begin
                data     = {16'd0, half_sel};
                misalign = addr[0];
            end
            // lw, and any code not listed above, passes the whole word
            default: begin
                data     = rdata;
                misalign = (addr != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_wbu.sv
// Writeback unit: accepts retiring instructions from the EXU, waits for load
// responses with a bounded timeout, and issues one register-file write per retire.
module ysyx_25040129_wbu
    import ysyx_25040129_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_wb_en,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic [31:0] result,
    output logic [4:0]  busy_rd,
    output logic        retire,
    output logic        err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wbu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0]       rd_reg;
    logic             wb_en_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       addr_reg;
    logic [31:0]      result_reg;
    logic             misalign_reg;
    logic             err_reg;

    logic             handshake;
    logic [31:0]      ext_data;
    logic             ext_misalign;

    ysyx_25040129_LDEXT u_ldext (
        .funct3   (funct3_reg),
        .addr     (addr_reg),
        .rdata    (mem_rdata),
        .data     (ext_data),
        .misalign (ext_misalign)
    );

    assign handshake = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b1;
        reg_write  = 1'b0;
        retire     = 1'b0;
        busy_rd    = 5'd0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = in_is_load ? ST_WAIT_MEM : ST_WRITE;
                end
            end
            ST_WAIT_MEM: begin
                in_ready = 1'b0;
                busy_rd  = wb_en_reg ? rd_reg : 5'd0;
                if (mem_rvalid) begin
                    state_next = ST_WRITE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WRITE: begin
                retire    = 1'b1;
                reg_write = wb_en_reg && (rd_reg != 5'd0) && !misalign_reg;
                busy_rd   = wb_en_reg ? rd_reg : 5'd0;
                if (in_valid) begin
                    state_next = in_is_load ? ST_WAIT_MEM : ST_WRITE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and load completion are mutually exclusive: in_ready is low in WAIT_MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            rd_reg       <= 5'd0;
            wb_en_reg    <= 1'b0;
            funct3_reg   <= 3'd0;
            addr_reg     <= 2'd0;
            result_reg   <= 32'd0;
            misalign_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (handshake) begin
                rd_reg       <= in_rd;
                wb_en_reg    <= in_wb_en;
                funct3_reg   <= in_funct3;
                addr_reg     <= in_result[1:0];
                result_reg   <= in_result;
                misalign_reg <= 1'b0;
                cnt_reg      <= '0;
            end else if (state_reg == ST_WAIT_MEM) begin
                if (mem_rvalid) begin
                    result_reg   <= ext_data;
                    misalign_reg <= ext_misalign;
                    err_reg      <= ext_misalign;
                end else if (cnt_reg == CNT_LAST) begin
                    err_reg <= 1'b1;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign rd     = rd_reg;
    assign result = result_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// Directed bench for the writeback unit: a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_ysyx_25040129_wbu;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] result;
    logic [4:0]  busy_rd;
    logic        retire;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_25040129_wbu #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_wb_en   (in_wb_en),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_result  (in_result),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rd         (rd),
        .reg_write  (reg_write),
        .result     (result),
        .busy_rd    (busy_rd),
        .retire     (retire),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics written as plain shifts and integer arithmetic.
    function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] word);
        logic [31:0] byte_v;
        logic [31:0] half_v;
        logic [31:0] val;
        logic        mis;
        int          sv;
        byte_v = (word >> (8 * a)) & 32'hFF;
        half_v = (word >> (16 * a[1])) & 32'hFFFF;
        val    = word;
        mis    = 1'b0;
        case (f3)
            3'b000: begin sv = int'(byte_v); if (sv >= 128) sv -= 256; val = sv; end
            3'b100: val = byte_v;
            3'b001: begin sv = int'(half_v); if (sv >= 32768) sv -= 65536; val = sv; mis = a[0]; end
            3'b101: begin val = half_v; mis = a[0]; end
            default: begin val = word; mis = (a != 2'd0); end
        endcase
        return {mis, val};
    endfunction

    // Model: one outstanding load at most; expectations describe the current cycle.
    logic        m_wait;
    int          m_waited;
    logic [4:0]  p_rd;
    logic        p_wb;
    logic [2:0]  p_f3;
    logic [1:0]  p_addr;
    logic [32:0] m_ld;
    logic [4:0]  e_rd;
    logic [4:0]  e_busy;
    logic [31:0] e_result;
    logic        e_write;
    logic        e_retire;
    logic        e_err;

    always_comb m_ld = model_load(p_f3, p_addr, mem_rdata);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait   <= 1'b0;
            m_waited <= 0;
            p_rd     <= 5'd0;
            p_wb     <= 1'b0;
            p_f3     <= 3'd0;
            p_addr   <= 2'd0;
            e_rd     <= 5'd0;
            e_busy   <= 5'd0;
            e_result <= 32'd0;
            e_write  <= 1'b0;
            e_retire <= 1'b0;
            e_err    <= 1'b0;
        end else begin
            e_write  <= 1'b0;
            e_retire <= 1'b0;
            e_err    <= 1'b0;
            if (m_wait) begin
                if (mem_rvalid) begin
                    m_wait   <= 1'b0;
                    e_retire <= 1'b1;
                    e_err    <= m_ld[32];
                    e_write  <= p_wb && (p_rd != 5'd0) && !m_ld[32];
                    e_result <= m_ld[31:0];
                    e_busy   <= p_wb ? p_rd : 5'd0;
                end else if (m_waited + 1 >= TO) begin
                    m_wait <= 1'b0;
                    e_err  <= 1'b1;
                    e_busy <= 5'd0;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (in_valid) begin
                e_rd   <= in_rd;
                e_busy <= in_wb_en ? in_rd : 5'd0;
                if (in_is_load) begin
                    m_wait   <= 1'b1;
                    m_waited <= 0;
                    p_rd     <= in_rd;
                    p_wb     <= in_wb_en;
                    p_f3     <= in_funct3;
                    p_addr   <= in_result[1:0];
                end else begin
                    e_retire <= 1'b1;
                    e_write  <= in_wb_en && (in_rd != 5'd0);
                    e_result <= in_result;
                end
            end else begin
                e_busy <= 5'd0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready",  32'(in_ready),  32'(!m_wait));
            chk("retire",    32'(retire),    32'(e_retire));
            chk("reg_write", 32'(reg_write), 32'(e_write));
            chk("err",       32'(err),       32'(e_err));
            chk("busy_rd",   32'(busy_rd),   32'(e_busy));
            chk("rd",        32'(rd),        32'(e_rd));
            if (e_write) chk("result", result, e_result);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] r, input logic wb, input logic ld,
                         input logic [2:0] f3, input logic [31:0] res);
        in_valid   = 1'b1;
        in_rd      = r;
        in_wb_en   = wb;
        in_is_load = ld;
        in_funct3  = f3;
        in_result  = res;
    endtask

    task automatic idle_in();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        in_wb_en   = 1'b0;
    endtask

    task automatic alu(input logic [4:0] r, input logic [31:0] res);
        offer(r, 1'b1, 1'b0, 3'd0, res);
        step();
        idle_in();
        $display("[%0t] alu rd=%0d result=%h -> reg_write=%0b retire=%0b", $time, r, res, reg_write, retire);
    endtask

    // Ends in the cycle after mem_rvalid (the write/retire cycle).
    task automatic do_load(input logic [4:0] r, input logic wb, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data, input int delay);
        offer(r, wb, 1'b1, f3, addr);
        step();
        idle_in();
        chk("load_not_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k < delay; k++) begin
            mem_rdata = $urandom;
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        $display("[%0t] load rd=%0d f3=%0d addr=%h data=%h -> result=%h wr=%0b err=%0b",
                 $time, r, f3, addr, data, result, reg_write, err);
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_rd      = 5'd0;
        in_wb_en   = 1'b0;
        in_is_load = 1'b0;
        in_funct3  = 3'd0;
        in_result  = 32'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_rd",        32'(rd),        32'd0);
        chk("rst_result",    result,         32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_retire",    32'(retire),    32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_busy_rd",   32'(busy_rd),   32'd0);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", 32'(in_ready), 32'd1);
        $display("[%0t] reset released", $time);

        alu(5'd5, 32'h0000_1234);
        chk("alu_write",  32'(reg_write), 32'd1);
        chk("alu_rd",     32'(rd),        32'd5);
        chk("alu_result", result,         32'h0000_1234);
        chk("alu_retire", 32'(retire),    32'd1);
        step();
        chk("alu_retire_done", 32'(retire), 32'd0);

        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        chk("stray_rvalid_retire", 32'(retire), 32'd0);
        $display("[%0t] stray mem_rvalid in idle", $time);

        do_load(5'd7, 1'b1, 3'b000, 32'h8000_0003, 32'h80FF_FFFF, 3);
        chk("lb_result", result, 32'hFFFF_FF80);
        chk("lb_write",  32'(reg_write), 32'd1);
        chk("lb_rd",     32'(rd), 32'd7);
        step();
        do_load(5'd8, 1'b1, 3'b100, 32'h8000_0003, 32'h80FF_FFFF, 3);
        chk("lbu_result", result, 32'h0000_0080);
        do_load(5'd9, 1'b1, 3'b001, 32'h0000_0002, 32'h8001_1234, 2);
        chk("lh_result", result, 32'hFFFF_8001);
        do_load(5'd10, 1'b1, 3'b101, 32'h0000_0000, 32'h8001_9234, 1);
        chk("lhu_result", result, 32'h0000_9234);
        do_load(5'd11, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678, 1);
        chk("lb_a1_result", result, 32'h0000_0056);
        do_load(5'd12, 1'b1, 3'b011, 32'h0000_0004, 32'hDEAD_BEEF, 2);
        chk("f3_011_as_lw", result, 32'hDEAD_BEEF);
        do_load(5'd13, 1'b0, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 1);
        chk("load_nowb_write", 32'(reg_write), 32'd0);
        step();

        do_load(5'd14, 1'b1, 3'b010, 32'h0000_0002, 32'h1111_2222, 2);
        chk("lw_mis_err",    32'(err),       32'd1);
        chk("lw_mis_retire", 32'(retire),    32'd1);
        chk("lw_mis_write",  32'(reg_write), 32'd0);
        do_load(5'd15, 1'b1, 3'b001, 32'h0000_0001, 32'h1111_2222, 1);
        chk("lh_mis_err", 32'(err), 32'd1);
        step();
        chk("err_pulse_one", 32'(err), 32'd0);

        offer(5'd16, 1'b1, 1'b1, 3'b010, 32'h0000_0010);
        step();
        idle_in();
        for (int j = 1; j < TO; j++) step();
        chk("to_err_early", 32'(err),      32'd0);
        chk("to_not_ready", 32'(in_ready), 32'd0);
        step();
        chk("to_err",    32'(err),      32'd1);
        chk("to_ready",  32'(in_ready), 32'd1);
        chk("to_retire", 32'(retire),   32'd0);
        $display("[%0t] load rd=16 timed out", $time);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        chk("to_late_rvalid", 32'(retire), 32'd0);

        alu(5'd0, 32'h0000_ABCD);
        chk("rd0_write",  32'(reg_write), 32'd0);
        chk("rd0_retire", 32'(retire),    32'd1);

        for (int i = 1; i <= 3; i++) begin
            alu(5'(i), 32'(i * 11));
            chk("b2b_write",  32'(reg_write), 32'd1);
            chk("b2b_result", result,         32'(i * 11));
        end
        alu(5'd4, 32'd44);
        do_load(5'd20, 1'b1, 3'b010, 32'h0000_0000, 32'h0BAD_F00D, 2);
        chk("write_to_load_result", result, 32'h0BAD_F00D);
        step();

        offer(5'd21, 1'b1, 1'b1, 3'b010, 32'h0000_0000);
        step();
        idle_in();
        step();
        chk("busy_in_wait", 32'(busy_rd), 32'd21);
        rst_n = 1'b0;
        #1 chk("rst_mid_busy", 32'(busy_rd), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("rst_mid_write",  32'(reg_write), 32'd0);
        chk("rst_mid_retire", 32'(retire),    32'd0);
        chk("rst_mid_busy2",  32'(busy_rd),   32'd0);
        $display("[%0t] reset during load, late response ignored", $time);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
